// File: rtl/dmem_ready_ctrl.sv
// Data-memory responder between the MEM stage and a variable-latency backing
// memory. Each pipeline access is turned into one request/acknowledge
// transaction on the bm_* side. mem_ready stays low until that transaction
// completes or the watchdog aborts it.
module dmem_ready_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              bm_req,
  output logic              bm_we,
  output logic [ADDR_W-1:0] bm_addr,
  output logic [DATA_W-1:0] bm_wdata,
  input  logic              bm_ack,
  input  logic [DATA_W-1:0] bm_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last wait-counter value before the watchdog fires. With this value,
  // bm_req is high for exactly TIMEOUT cycles.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;
  logic       err;
  logic       access;
  logic       timeout_hit;

  // A write wins when both requests are asserted together.
  assign access      = mem_read | mem_write;
  assign timeout_hit = (cnt == TO_LAST) && !bm_ack;
  assign mem_err     = (state == DONE) && err;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and stall logic. mem_ready depends only on state and on the
  // pipeline requests, never on bm_ack.
  always_comb begin
    state_next = state;
    mem_ready  = 1'b0;
    case (state)
      IDLE: begin
        mem_ready = !access;
        if (access) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (bm_ack || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        mem_ready  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Backing-memory request registers, wait counter, load data and error flag.
  // In REQ, bm_we doubles as the read/write indicator of the access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bm_req   <= 1'b0;
      bm_we    <= 1'b0;
      bm_addr  <= '0;
      bm_wdata <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      cnt      <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            bm_req   <= 1'b1;
            bm_we    <= mem_write;
            bm_addr  <= addr;
            bm_wdata <= wdata;
            cnt      <= 8'd0;
          end
        end
        REQ: begin
          if (bm_ack) begin
            if (!bm_we) begin
              rdata <= bm_rdata;
            end
            bm_req <= 1'b0;
            bm_we  <= 1'b0;
          end else if (timeout_hit) begin
            if (!bm_we) begin
              rdata <= '0;
            end
            bm_req <= 1'b0;
            bm_we  <= 1'b0;
            err    <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          err <= 1'b0;
        end
        default: begin
          err <= 1'b0;
        end
      endcase
    end
  end

endmodule
